// File: rtl/audio_play_pkg.sv
// Shared types, reciprocal table and saturation helper for the playback engine.
package audio_play_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READY,
    PAUSED
  } play_state_t;

  localparam int RECIP_FRAC = 12;

  // round(4096/N) for N = 1..8; wider speed selects fall back to the same rounding rule.
  localparam int RECIP_LUT [1:8] = '{4096, 2048, 1365, 1024, 819, 683, 585, 512};

  function automatic int recip_of(input int n);
    if (n >= 1 && n <= 8) return RECIP_LUT[n];
    return (4096 + n / 2) / n;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/play_interp.sv
// Combinational linear interpolator between two adjacent samples (built only with LINEAR_INTERP_EN).
`ifdef LINEAR_INTERP_EN
module play_interp
  import audio_play_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int SPEED_W  = 3
) (
  input  logic [SAMPLE_W-1:0] s0,
  input  logic [SAMPLE_W-1:0] s1,
  input  logic [SPEED_W-1:0]  k,
  input  logic [SPEED_W-1:0]  spd,
  output logic [SAMPLE_W-1:0] sample
);

  localparam int W  = SAMPLE_W + SPEED_W + 14;
  localparam int NS = 2 ** SPEED_W;

  logic [13:0] recip_tab [NS];

  for (genvar g = 0; g < NS; g++) begin : g_recip
    assign recip_tab[g] = 14'(recip_of(g + 1));
  end

  logic signed [W-1:0] diff_w;
  logic signed [W-1:0] kr_w;
  logic signed [W-1:0] prod_w;
  logic signed [W-1:0] sum_w;

  // k * recip never reaches 4096, so the product fits and the result stays between s0 and s1.
  assign diff_w = W'($signed(s1)) - W'($signed(s0));
  assign kr_w   = $signed(W'(k)) * $signed(W'(recip_tab[spd]));
  assign prod_w = diff_w * kr_w;
  assign sum_w  = W'($signed(s0)) + (prod_w >>> RECIP_FRAC);
  assign sample = SAMPLE_W'(sat_signed(64'(sum_w), SAMPLE_W));

endmodule
`endif

// File: rtl/audio_play_engine.sv
// SRAM-to-DAC playback engine with fast (skip) and slow (repeat) modes.
// Define LINEAR_INTERP_EN to interpolate between samples in slow mode.
module audio_play_engine
  import audio_play_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 20,
  parameter int SPEED_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic                stop,
  input  logic                slow_mode,
  input  logic [SPEED_W-1:0]  speed,
  input  logic [ADDR_W-1:0]   end_addr,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  input  logic                sample_req,
  output logic [SAMPLE_W-1:0] dac_data,
  output logic                playing,
  output logic                done
);

  play_state_t         state;
  logic [ADDR_W-1:0]   addr;
  logic [SPEED_W-1:0]  spd;
  logic [SPEED_W-1:0]  k;
  logic                slow_lat;
  logic [SAMPLE_W-1:0] s0_p0;
  logic [SAMPLE_W-1:0] cur_sample;
  logic [ADDR_W:0]     next_addr;
  logic                past_end;
  logic                advance;
  logic                ack_ok;

  assign ack_ok    = (state == FETCH) && mem_req && mem_ack && !stop && !pause;
  assign next_addr = {1'b0, addr} + (slow_lat ? (ADDR_W+1)'(1)
                                              : (ADDR_W+1)'(spd) + (ADDR_W+1)'(1));
  // The extra bit makes a carry out compare as "beyond the recording".
  assign past_end  = next_addr > {1'b0, end_addr};
  assign advance   = slow_lat ? (k == spd) : 1'b1;

`ifdef LINEAR_INTERP_EN
  logic                fetch_hi;
  logic                at_last;
  logic [SAMPLE_W-1:0] s1_p0;
  logic [SAMPLE_W-1:0] interp_out;

  assign at_last = (addr == end_addr);

  play_interp #(
    .SAMPLE_W (SAMPLE_W),
    .SPEED_W  (SPEED_W)
  ) u_interp (
    .s0     (s0_p0),
    .s1     (s1_p0),
    .k      (k),
    .spd    (spd),
    .sample (interp_out)
  );

  assign cur_sample = slow_lat ? interp_out : s0_p0;

  // Sample capture: the last address has no successor, so s1 mirrors s0 there.
  always_ff @(posedge clk) begin
    if (ack_ok) begin
      if (!fetch_hi) begin
        s0_p0 <= mem_rdata;
        if (at_last) s1_p0 <= mem_rdata;
      end else begin
        s1_p0 <= mem_rdata;
      end
    end
  end
`else
  assign cur_sample = s0_p0;

  // Sample capture
  always_ff @(posedge clk) begin
    if (ack_ok) s0_p0 <= mem_rdata;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
      dac_data <= '0;
      playing  <= 1'b0;
      done     <= 1'b0;
      k        <= '0;
      spd      <= '0;
      slow_lat <= 1'b0;
`ifdef LINEAR_INTERP_EN
      fetch_hi <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        addr     <= '0;
        mem_addr <= '0;
        mem_req  <= 1'b0;
        dac_data <= '0;
        playing  <= 1'b0;
        k        <= '0;
`ifdef LINEAR_INTERP_EN
        fetch_hi <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            dac_data <= '0;
            if (start && !pause) begin
              state    <= FETCH;
              addr     <= '0;
              mem_addr <= '0;
              mem_req  <= 1'b1;
              playing  <= 1'b1;
            end
          end

          FETCH: begin
            if (pause) begin
              state    <= PAUSED;
              mem_req  <= 1'b0;
              playing  <= 1'b0;
`ifdef LINEAR_INTERP_EN
              fetch_hi <= 1'b0;
`endif
            end else if (mem_req && mem_ack) begin
              mem_req <= 1'b0;
`ifdef LINEAR_INTERP_EN
              if (!fetch_hi) begin
                spd      <= speed;
                slow_lat <= slow_mode;
                k        <= '0;
              end
              if (!fetch_hi && slow_mode && !at_last) begin
                fetch_hi <= 1'b1;
              end else begin
                fetch_hi <= 1'b0;
                state    <= READY;
              end
`else
              spd      <= speed;
              slow_lat <= slow_mode;
              k        <= '0;
              state    <= READY;
`endif
            end
`ifdef LINEAR_INTERP_EN
            else if (fetch_hi && !mem_req) begin
              // One idle cycle between the two reads keeps mem_addr stable under each request.
              mem_req  <= 1'b1;
              mem_addr <= addr + ADDR_W'(1);
            end
`endif
          end

          READY: begin
            if (pause) begin
              state   <= PAUSED;
              playing <= 1'b0;
              k       <= '0;
            end else if (sample_req) begin
              dac_data <= cur_sample;
              if (advance) begin
                k <= '0;
                if (past_end) begin
                  done     <= 1'b1;
                  addr     <= '0;
                  mem_addr <= '0;
                  playing  <= 1'b0;
                  state    <= IDLE;
                end else begin
                  addr     <= next_addr[ADDR_W-1:0];
                  mem_addr <= next_addr[ADDR_W-1:0];
                  mem_req  <= 1'b1;
                  state    <= FETCH;
                end
              end else begin
                k <= k + SPEED_W'(1);
              end
            end
          end

          PAUSED: begin
            if (start) begin
              state    <= FETCH;
              mem_addr <= addr;
              mem_req  <= 1'b1;
              playing  <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
